control_pipeline: RTL

- Consumes the decode-stage control word from the main controller and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core.
- Resolves branches and jumps in EX using the ALU condition flags, and drives PCSrcE to the fetch mux.
- Exposes per-stage RegWrite, ResultSrc and rd so the hazard unit can compute forwarding and stalls.
- Supports bubble insertion into EX through FlushE.

---
 rtl/control_pipeline_if.sv | 70 +++++++
 rtl/control_pipeline.sv | 114 +++++++++++
 2 files changed

// File: rtl/control_pipeline_if.sv
// Decode-to-writeback control bundle: D-stage control word and EX flags in, per-stage control out.
// Carries no handshake; the pipeline advances on every clock edge.
interface control_pipeline_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTL_W   = 3,
    parameter int IMMSRC_W   = 3
);
    // hazard unit
    logic                  FlushE;

    // decode-stage control word
    logic                  JumpD;
    logic                  BranchD;
    logic                  JALRSrcD;
    logic                  BranchSrcD;
    logic [1:0]            ResultSrcD;
    logic                  MemWriteD;
    logic [ALUCTL_W-1:0]   ALUControlD;
    logic                  ALUSrcD;
    logic [IMMSRC_W-1:0]   ImmSrcD;
    logic                  RegWriteD;
    logic [2:0]            funct3D;
    logic [REG_ADDR_W-1:0] RdD;

    // ALU condition flags for the instruction currently in EX
    logic                  ZeroE;
    logic                  LtE;
    logic                  LtuE;

    // EX stage
    logic [ALUCTL_W-1:0]   ALUControlE;
    logic                  ALUSrcE;
    logic                  JALRSrcE;
    logic                  BranchSrcE;
    logic [IMMSRC_W-1:0]   ImmSrcE;
    logic                  PCSrcE;
    logic [1:0]            ResultSrcE;
    logic [REG_ADDR_W-1:0] RdE;

    // MEM stage
    logic                  RegWriteM;
    logic                  MemWriteM;
    logic [1:0]            ResultSrcM;
    logic [REG_ADDR_W-1:0] RdM;

    // WB stage
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic [REG_ADDR_W-1:0] RdW;

    modport master (
        output FlushE,
        output JumpD, BranchD, JALRSrcD, BranchSrcD, ResultSrcD, MemWriteD,
        output ALUControlD, ALUSrcD, ImmSrcD, RegWriteD, funct3D, RdD,
        output ZeroE, LtE, LtuE,
        input  ALUControlE, ALUSrcE, JALRSrcE, BranchSrcE, ImmSrcE, PCSrcE, ResultSrcE, RdE,
        input  RegWriteM, MemWriteM, ResultSrcM, RdM,
        input  RegWriteW, ResultSrcW, RdW
    );

    modport slave (
        input  FlushE,
        input  JumpD, BranchD, JALRSrcD, BranchSrcD, ResultSrcD, MemWriteD,
        input  ALUControlD, ALUSrcD, ImmSrcD, RegWriteD, funct3D, RdD,
        input  ZeroE, LtE, LtuE,
        output ALUControlE, ALUSrcE, JALRSrcE, BranchSrcE, ImmSrcE, PCSrcE, ResultSrcE, RdE,
        output RegWriteM, MemWriteM, ResultSrcM, RdM,
        output RegWriteW, ResultSrcW, RdW
    );
endinterface

// File: rtl/control_pipeline.sv
// Carries the decode control word through ID/EX, EX/MEM, MEM/WB and resolves branches/jumps in EX.
// Latency: D inputs reach E outputs after 1 edge, M after 2, W after 3; PCSrcE is combinational in EX.
// No backpressure: every stage advances each edge; FlushE turns the incoming EX word into a bubble.
module control_pipeline #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTL_W   = 3,
    parameter int IMMSRC_W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    control_pipeline_if.slave bus
);

    typedef struct packed {
        logic                  jump;
        logic                  branch;
        logic                  jalr_src;
        logic                  branch_src;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [ALUCTL_W-1:0]   alu_control;
        logic                  alu_src;
        logic [IMMSRC_W-1:0]   imm_src;
        logic                  reg_write;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } wb_t;

    ex_t  ex_d;
    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    logic br_cond;

    always_comb begin
        ex_d             = '0;
        ex_d.jump        = bus.JumpD;
        ex_d.branch      = bus.BranchD;
        ex_d.jalr_src    = bus.JALRSrcD;
        ex_d.branch_src  = bus.BranchSrcD;
        ex_d.result_src  = bus.ResultSrcD;
        ex_d.mem_write   = bus.MemWriteD;
        ex_d.alu_control = bus.ALUControlD;
        ex_d.alu_src     = bus.ALUSrcD;
        ex_d.imm_src     = bus.ImmSrcD;
        ex_d.reg_write   = bus.RegWriteD;
        ex_d.funct3      = bus.funct3D;
        ex_d.rd          = bus.RdD;
    end

    // A bubble is the all-zero word: no register/memory write, no redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q             <= bus.FlushE ? ex_t'('0) : ex_d;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.result_src <= ex_q.result_src;
            mem_q.rd         <= ex_q.rd;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.result_src  <= mem_q.result_src;
            wb_q.rd          <= mem_q.rd;
        end
    end

    // funct3 010/011 are not branch encodings and never take.
    always_comb begin
        br_cond = 1'b0;
        case (ex_q.funct3)
            3'b000:  br_cond =  bus.ZeroE;
            3'b001:  br_cond = !bus.ZeroE;
            3'b100:  br_cond =  bus.LtE;
            3'b101:  br_cond = !bus.LtE;
            3'b110:  br_cond =  bus.LtuE;
            3'b111:  br_cond = !bus.LtuE;
            default: br_cond = 1'b0;
        endcase
    end

    assign bus.PCSrcE      = ex_q.jump | (ex_q.branch & br_cond);
    assign bus.ALUControlE = ex_q.alu_control;
    assign bus.ALUSrcE     = ex_q.alu_src;
    assign bus.JALRSrcE    = ex_q.jalr_src;
    assign bus.BranchSrcE  = ex_q.branch_src;
    assign bus.ImmSrcE     = ex_q.imm_src;
    assign bus.ResultSrcE  = ex_q.result_src;
    assign bus.RdE         = ex_q.rd;

    assign bus.RegWriteM   = mem_q.reg_write;
    assign bus.MemWriteM   = mem_q.mem_write;
    assign bus.ResultSrcM  = mem_q.result_src;
    assign bus.RdM         = mem_q.rd;

    assign bus.RegWriteW   = wb_q.reg_write;
    assign bus.ResultSrcW  = wb_q.result_src;
    assign bus.RdW         = wb_q.rd;

endmodule
